// File: rtl/dmem_responder.sv
// Single-port data memory responder for a CPU data bus.
// Accepts one request at a time, optionally inserts wait states, and
// answers with a one-cycle ack; misaligned or out-of-range requests are
// answered immediately with err and never touch the array or counters.
//
// state | meaning
// IDLE  | ready to accept a request
// WAIT  | valid request latched, burning wait states
// ACK   | one-cycle completion (ack/err valid, load data on the bus)
module dmem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dmem_req,
  input  logic        dmem_wen,
  input  logic [31:0] dmem_addr,
  inout  wire  [31:0] dmem_data,
  output logic        dmem_ack,
  output logic        dmem_err,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
  // WAIT exits when the counter reads zero, so it is loaded with one less
  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

  state_t        state;
  logic [3:0]    wait_cnt;
  logic          lat_wen;
  logic [AW-1:0] lat_idx;
  logic [31:0]   lat_data;
  logic [31:0]   rdata;
  logic          drive_en;
  logic [31:0]   mem [DEPTH_WORDS];

  logic          req_err;
  logic          go_direct;
  logic          go_from_wait;
  logic          mem_en;
  logic          acc_wen;
  logic [AW-1:0] acc_idx;
  logic [31:0]   acc_data;

  // Decode the incoming request and select the source for the array access
  // (straight from the bus when there are no wait states, else the latch).
  always_comb begin
    req_err      = (dmem_addr[1:0] != 2'b00) || ({1'b0, dmem_addr} >= ADDR_LIMIT);
    go_direct    = (state == IDLE) && dmem_req && !req_err && (WAIT_CYCLES == 0);
    go_from_wait = (state == WAIT) && (wait_cnt == 4'd0);
    mem_en       = !rst && (go_direct || go_from_wait);
    acc_wen      = go_direct ? dmem_wen : lat_wen;
    acc_idx      = go_direct ? dmem_addr[AW+1:2] : lat_idx;
    acc_data     = go_direct ? dmem_data : lat_data;
  end

  // Array write and read happen on the edge that enters ACK; reset gating
  // in mem_en guarantees an aborted store never commits.
  always_ff @(posedge clk) begin
    if (mem_en && acc_wen) mem[acc_idx] <= acc_data;
  end

  // Load data register, presented on the bus during the ACK cycle only.
  always_ff @(posedge clk) begin
    if (mem_en && !acc_wen) rdata <= mem[acc_idx];
  end

  // Control FSM with registered ack/err/drive and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      wait_cnt <= 4'd0;
      dmem_ack <= 1'b0;
      dmem_err <= 1'b0;
      drive_en <= 1'b0;
      rd_count <= 16'd0;
      wr_count <= 16'd0;
    end else begin
      dmem_ack <= 1'b0;
      dmem_err <= 1'b0;
      drive_en <= 1'b0;
      case (state)
        IDLE: begin
          if (dmem_req) begin
            lat_wen  <= dmem_wen;
            lat_idx  <= dmem_addr[AW+1:2];
            lat_data <= dmem_data;
            if (req_err) begin
              state    <= ACK;
              dmem_ack <= 1'b1;
              dmem_err <= 1'b1;
            end else if (WAIT_CYCLES == 0) begin
              state    <= ACK;
              dmem_ack <= 1'b1;
              drive_en <= !dmem_wen;
              if (dmem_wen) begin
                if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
              end else begin
                if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
              end
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state    <= ACK;
            dmem_ack <= 1'b1;
            drive_en <= !lat_wen;
            if (lat_wen) begin
              if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end else begin
              if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        ACK:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign dmem_data = drive_en ? rdata : 32'bz;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: three instances with 0, 3 and 2
// wait states share the request bus; only the selected one sees dmem_req.
module tb_dmem_responder;

  typedef struct {
    int          inst;
    bit          err;
    bit          load;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic [2:0]  rst_v = 3'b111;
  logic [2:0]  req_v = 3'b000;
  logic [2:0]  drv = 3'b000;
  logic        wen = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  exp_t        q[$];

  wire [2:0]  ack_v, err_v;
  wire [31:0] bus0, bus1, bus2;
  wire [15:0] rd0, wr0, rd1, wr1, rd2, wr2;

  pullup (bus0);
  pullup (bus1);
  pullup (bus2);

  assign bus0 = drv[0] ? wdata : 32'bz;
  assign bus1 = drv[1] ? wdata : 32'bz;
  assign bus2 = drv[2] ? wdata : 32'bz;

  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u0 (
    .clk(clk), .rst(rst_v[0]), .dmem_req(req_v[0]), .dmem_wen(wen), .dmem_addr(addr),
    .dmem_data(bus0), .dmem_ack(ack_v[0]), .dmem_err(err_v[0]), .rd_count(rd0), .wr_count(wr0));
  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u1 (
    .clk(clk), .rst(rst_v[1]), .dmem_req(req_v[1]), .dmem_wen(wen), .dmem_addr(addr),
    .dmem_data(bus1), .dmem_ack(ack_v[1]), .dmem_err(err_v[1]), .rd_count(rd1), .wr_count(wr1));
  dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) u2 (
    .clk(clk), .rst(rst_v[2]), .dmem_req(req_v[2]), .dmem_wen(wen), .dmem_addr(addr),
    .dmem_data(bus2), .dmem_ack(ack_v[2]), .dmem_err(err_v[2]), .rd_count(rd2), .wr_count(wr2));

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #100000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: every ack is matched against the head of the scoreboard;
  // whenever an instance is not acking and the bench is not driving, its bus must float.
  always @(negedge clk) begin
    exp_t        x;
    logic [31:0] bv;
    for (int k = 0; k < 3; k++) begin
      bv = (k == 0) ? bus0 : (k == 1) ? bus1 : bus2;
      if (ack_v[k]) begin
        n_checks++;
        if (q.size() == 0 || q[0].inst != k) begin
          n_fail++;
          $display("FAIL unexpected_ack inst=%0d cyc=%0d", k, cyc);
        end else begin
          x = q.pop_front();
          check($sformatf("ack_cycle inst%0d", k), cyc, x.cyc);
          check($sformatf("ack_err inst%0d", k), {31'd0, err_v[k]}, {31'd0, x.err});
          if (x.load && !x.err) check($sformatf("load_data inst%0d", k), bv, x.data);
          else check($sformatf("ack_bus_float inst%0d", k), bv, 32'hFFFF_FFFF);
        end
      end else if (!drv[k]) begin
        check($sformatf("bus_float inst%0d cyc%0d", k, cyc), bv, 32'hFFFF_FFFF);
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL ack_timeout pending=%0d actual=none required=ack", q.size());
      q.delete();
    end
  endtask

  // Called at a negedge; drives one request for one cycle and waits for its ack.
  task automatic issue(input int k, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input bit e, input int lat);
    exp_t x;
    req_v    = 3'b000;
    req_v[k] = 1'b1;
    drv      = 3'b000;
    drv[k]   = w;
    wen      = w;
    addr     = a;
    wdata    = d;
    x.inst = k; x.err = e; x.load = !w; x.data = d; x.cyc = cyc + lat;
    q.push_back(x);
    @(negedge clk);
    req_v = 3'b000;
    drv   = 3'b000;
    drain();
  endtask

  initial begin
    exp_t x;
    int   c;
    repeat (3) @(negedge clk);
    check("rst_ack", {29'd0, ack_v}, 32'd0);
    check("rst_err", {29'd0, err_v}, 32'd0);
    check("rst_counts0", {rd0, wr0}, 32'd0);
    check("rst_counts1", {rd1, wr1}, 32'd0);
    check("rst_counts2", {rd2, wr2}, 32'd0);
    rst_v = 3'b000;

    // zero wait states: first request on the first edge out of reset
    issue(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1);
    issue(0, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 1);
    check("w0_counts_a", {rd0, wr0}, {16'd1, 16'd1});
    issue(0, 1'b1, 32'h0,   32'hA5A5_0001, 1'b0, 1);
    issue(0, 1'b1, 32'hFFC, 32'h0BAD_F00D, 1'b0, 1);
    issue(0, 1'b0, 32'hFFC, 32'h0BAD_F00D, 1'b0, 1);
    // error requests: misaligned, just past the end, far out of range
    issue(0, 1'b0, 32'h6,         32'h0,         1'b1, 1);
    issue(0, 1'b1, 32'h1000,      32'h1111_1111, 1'b1, 1);
    issue(0, 1'b1, 32'h8000_0000, 32'h2222_2222, 1'b1, 1);
    issue(0, 1'b1, 32'h3,         32'h3333_3333, 1'b1, 1);
    check("w0_counts_err", {rd0, wr0}, {16'd2, 16'd3});
    issue(0, 1'b0, 32'h0, 32'hA5A5_0001, 1'b0, 1);
    check("w0_counts_b", {rd0, wr0}, {16'd3, 16'd3});

    // back-to-back loads, req held 10 cycles -> 5 acks every 2 cycles
    c = cyc;
    req_v = 3'b001; wen = 1'b0; addr = 32'h10;
    for (int i = 0; i < 5; i++) begin
      x.inst = 0; x.err = 1'b0; x.load = 1'b1; x.data = 32'hDEAD_BEEF; x.cyc = c + 1 + 2 * i;
      q.push_back(x);
    end
    repeat (10) @(negedge clk);
    req_v = 3'b000;
    drain();
    check("w0_counts_b2b", {rd0, wr0}, {16'd8, 16'd3});

    // store counter saturation
    force u0.wr_count = 16'hFFFE;
    @(negedge clk);
    release u0.wr_count;
    check("sat_preset", {16'd0, wr0}, 32'h0000_FFFE);
    for (int i = 0; i < 3; i++) begin
      issue(0, 1'b1, 32'h40, 32'h4000_0000 + 32'(i), 1'b0, 1);
      check($sformatf("sat_store%0d", i), {16'd0, wr0}, 32'h0000_FFFF);
    end
    check("sat_rd_untouched", {16'd0, rd0}, 32'd8);

    // three wait states
    issue(1, 1'b1, 32'h0,    32'hCAFE_0003, 1'b0, 4);
    issue(1, 1'b0, 32'h0,    32'hCAFE_0003, 1'b0, 4);
    issue(1, 1'b1, 32'h2,    32'h5555_5555, 1'b1, 1);
    issue(1, 1'b0, 32'h1000, 32'h0,         1'b1, 1);
    issue(1, 1'b0, 32'h0,    32'hCAFE_0003, 1'b0, 4);
    check("w3_counts", {rd1, wr1}, {16'd2, 16'd1});

    // two wait states, reset in the first WAIT cycle aborts the store
    issue(2, 1'b1, 32'h20, 32'h0000_5A5A, 1'b0, 3);
    check("w2_counts_pre", {rd2, wr2}, {16'd0, 16'd1});
    req_v = 3'b100; drv = 3'b100; wen = 1'b1; addr = 32'h20; wdata = 32'h1234_5678;
    @(negedge clk);
    req_v = 3'b000; drv = 3'b000; rst_v[2] = 1'b1;
    @(negedge clk);
    rst_v[2] = 1'b0;
    check("abort_counts", {rd2, wr2}, 32'd0);
    repeat (6) @(negedge clk);
    issue(2, 1'b0, 32'h20, 32'h0000_5A5A, 1'b0, 3);
    check("w2_counts_post", {rd2, wr2}, {16'd1, 16'd0});

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, is the number of 32-bit words of storage and SHALL be a power of two, at least 2.
REQ-002 Parameter WAIT_CYCLES, default 0, is the number of extra wait states inserted before each non-error acknowledge; legal range is 0..15.
REQ-003 Port clk, input, 1 bit, is the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1 bit, is the reset: one clock, synchronous, active-high.
REQ-005 Port dmem_req, input, 1 bit, is the request valid from the CPU.
REQ-006 Port dmem_wen, input, 1 bit, selects store (1) or load (0); it is qualified by dmem_req.
REQ-007 Port dmem_addr, input, 32 bits, is the byte address of the request.
REQ-008 Port dmem_data, inout, 32 bits, carries store data from the CPU and load data from this block.
REQ-009 Port dmem_ack, output, 1 bit, is a one-cycle completion pulse.
REQ-010 Port dmem_err, output, 1 bit, is an error flag that is only valid while dmem_ack=1.
REQ-011 Port rd_count, output, 16 bits, counts completed loads.
REQ-012 Port wr_count, output, 16 bits, counts completed stores.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, WAIT, ACK.
REQ-014 A request SHALL be accepted only in IDLE with dmem_req=1; on acceptance the block SHALL latch dmem_wen, dmem_addr, and the dmem_data value sampled at that edge.
REQ-015 An accepted request is in error if dmem_addr[1:0]!=0 (misaligned) or dmem_addr >= 4*DEPTH_WORDS (out of range).
REQ-016 For an error request, IDLE SHALL go to ACK regardless of WAIT_CYCLES; the ACK cycle SHALL assert dmem_err=1 with no array access and no counter change.
REQ-017 For a valid request with WAIT_CYCLES=0, IDLE SHALL go to ACK; otherwise IDLE SHALL go to WAIT.
REQ-018 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by an internal 4-bit down-counter, and then go to ACK.
REQ-019 Acknowledge latency SHALL be 1+WAIT_CYCLES cycles after the accepting edge for a valid request, and 1 cycle for an error request.
REQ-020 ACK SHALL last exactly one cycle with dmem_ack=1 and SHALL always return to IDLE; dmem_req is ignored during WAIT and ACK.
REQ-021 A dmem_req still high in the cycle after ACK SHALL be accepted as a new request, so back-to-back requests SHALL produce ack every 2+WAIT_CYCLES cycles.
REQ-022 A store SHALL write the latched data to word index addr[log2(DEPTH_WORDS)+1:2] on the edge that enters ACK.
REQ-023 For a load, the array SHALL be read on the edge that enters ACK, and dmem_data SHALL be driven with that word only during the ACK cycle.
REQ-024 dmem_data SHALL be high-impedance in every other cycle, including during store ACK and error ACK.
REQ-025 A load from a word written in an earlier request SHALL return the newly written value; no write-to-read bypass within the same cycle is needed.
REQ-026 rd_count SHALL increment on each non-error load ACK and wr_count on each non-error store ACK; both SHALL saturate at 16'hFFFF with no wrap.
REQ-027 dmem_ack and dmem_err SHALL be registered outputs, with no combinational path from the inputs.

Reset
REQ-028 While rst=1 the block SHALL hold: state=IDLE, dmem_ack=0, dmem_err=0, rd_count=0, wr_count=0, wait counter=0, and dmem_data high-impedance.
REQ-029 Reset SHALL NOT clear the array contents.
REQ-030 Reset asserted during WAIT or ACK SHALL abort the request: no ack is issued, and a store not yet committed to the array SHALL NOT be written.
REQ-031 The first request SHALL be accepted on the first edge with rst=0 and dmem_req=1.

Verification
REQ-032 With WAIT_CYCLES=0: store 0xDEADBEEF to 0x10, then load 0x10 -> ack 1 cycle after each accept, dmem_data=0xDEADBEEF during the load ACK, err=0, rd_count=1, wr_count=1.
REQ-033 With WAIT_CYCLES=3: load 0x0 -> ack exactly 4 cycles after accept, dmem_data high-impedance in every cycle except ACK.
REQ-034 Load 0x6 and store to 0x1000 (DEPTH_WORDS=1024) -> ack+err after 1 cycle each, counters unchanged, and a later load of 0x0 shows the array unmodified.
REQ-035 dmem_req held at 1 for 10 cycles with WAIT_CYCLES=0 -> 5 acks, one every 2 cycles.
REQ-036 Store 0x12345678 to 0x20 with WAIT_CYCLES=2 and rst pulsed in the first WAIT cycle -> no ack, and a later load of 0x20 returns the old value.
REQ-037 Force wr_count to 0xFFFE and perform 3 stores -> wr_count holds at 0xFFFF.
